// File: rtl/uba_intack.sv
// Interrupt acknowledge arbiter for the Unibus adapter.
// On a CPU "who are you" read it picks the highest-priority eligible device
// request, acknowledges it, waits up to 64 cycles for the device vector and
// returns that vector (or a no-vector indication) to the CPU.
module uba_intack (
  input  logic         clk,
  input  logic         rst,
  input  logic         wruREAD,
  input  logic [2:0]   ackPI,
  input  logic [2:0]   statPIH,
  input  logic [2:0]   statPIL,
  input  logic [7:4]   devINTR [1:4],
  output logic [1:4]   devACKO,
  output logic [7:4]   devACKBR,
  input  logic [1:4]   devVACK,
  input  logic [18:35] devVECT [1:4],
  output logic [0:35]  busVECT,
  output logic         busVALID,
  output logic         busNOVECT
);

  typedef enum logic [1:0] {StIdle, StArb, StAck, StDone} stateE;

  stateE       stateQ, stateD;
  logic [2:0]  ackPiQ, ackPiD;
  // Winner encoding: device index 0..3 = device 1..4, level index 0..3 = BR4..BR7.
  logic [1:0]  winDevQ, winDevD;
  logic [1:0]  winLvlQ, winLvlD;
  logic [5:0]  cntQ, cntD;
  logic        novectQ, novectD;
  logic [0:35] vectD;

  logic [1:4]  ackoD;
  logic [7:4]  ackbrD;
  logic        validD;
  logic        novOutD;

  logic        hiEn, loEn;
  logic        found;
  logic [1:0]  arbDev, arbLvl;
  logic        winVack;
  logic [18:35] winVect;

  // Priority arbitration over all eligible requests: BR7 first, device 1 first.
  always_comb begin
    hiEn   = (statPIH == ackPiQ) && (ackPiQ != 3'd0);
    loEn   = (statPIL == ackPiQ) && (ackPiQ != 3'd0);
    found  = 1'b0;
    arbDev = 2'd0;
    arbLvl = 2'd0;
    for (int l = 7; l >= 4; l--) begin
      for (int d = 1; d <= 4; d++) begin
        if (!found && devINTR[d][l] && ((l >= 6) ? hiEn : loEn)) begin
          found  = 1'b1;
          arbDev = 2'(d - 1);
          arbLvl = 2'(l - 4);
        end
      end
    end
  end

  // Select the latched winner's vector-valid and vector; other devices are ignored.
  always_comb begin
    winVack = 1'b0;
    winVect = '0;
    unique case (winDevQ)
      2'd0: begin winVack = devVACK[1]; winVect = devVECT[1]; end
      2'd1: begin winVack = devVACK[2]; winVect = devVECT[2]; end
      2'd2: begin winVack = devVACK[3]; winVect = devVECT[3]; end
      2'd3: begin winVack = devVACK[4]; winVect = devVECT[4]; end
      default: begin winVack = 1'b0; winVect = '0; end
    endcase
  end

  // Next-state and datapath update logic.
  always_comb begin
    stateD  = stateQ;
    ackPiD  = ackPiQ;
    winDevD = winDevQ;
    winLvlD = winLvlQ;
    cntD    = cntQ;
    novectD = novectQ;
    vectD   = busVECT;
    unique case (stateQ)
      StIdle: begin
        if (wruREAD) begin
          ackPiD = ackPI;
          stateD = StArb;
        end
      end
      StArb: begin
        if (found) begin
          winDevD = arbDev;
          winLvlD = arbLvl;
          cntD    = 6'd0;
          novectD = 1'b0;
          stateD  = StAck;
        end else begin
          novectD = 1'b1;
          vectD   = '0;
          stateD  = StDone;
        end
      end
      StAck: begin
        // A vector arriving on the last counted cycle still wins over the timeout.
        if (winVack) begin
          novectD = 1'b0;
          vectD   = {18'b0, winVect};
          stateD  = StDone;
        end else if (cntQ == 6'd63) begin
          novectD = 1'b1;
          vectD   = '0;
          stateD  = StDone;
        end else begin
          cntD = cntQ + 6'd1;
        end
      end
      StDone: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  // Output decode from the next state so every output comes straight from a flop.
  always_comb begin
    ackoD   = '0;
    ackbrD  = '0;
    validD  = 1'b0;
    novOutD = 1'b0;
    if (stateD == StAck) begin
      ackoD  = 4'b1000 >> winDevD;
      ackbrD = 4'b0001 << winLvlD;
    end
    if (stateD == StDone) begin
      validD  = 1'b1;
      novOutD = novectD;
    end
  end

  // State register; reset clears everything, including in-flight acknowledges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ  <= StIdle;
      ackPiQ  <= 3'd0;
      winDevQ <= 2'd0;
      winLvlQ <= 2'd0;
      cntQ    <= 6'd0;
      novectQ <= 1'b0;
    end else begin
      stateQ  <= stateD;
      ackPiQ  <= ackPiD;
      winDevQ <= winDevD;
      winLvlQ <= winLvlD;
      cntQ    <= cntD;
      novectQ <= novectD;
    end
  end

  // Registered bus and acknowledge outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      devACKO   <= '0;
      devACKBR  <= '0;
      busVECT   <= '0;
      busVALID  <= 1'b0;
      busNOVECT <= 1'b0;
    end else begin
      devACKO   <= ackoD;
      devACKBR  <= ackbrD;
      busVECT   <= vectD;
      busVALID  <= validD;
      busNOVECT <= novOutD;
    end
  end

endmodule

// File: tb/tb_uba_intack.sv
// Scoreboarded bench for uba_intack: each transaction pushes its expected bus
// response; a monitor pops and compares on every busVALID strobe.
module tb_uba_intack;

  logic         clk = 1'b0;
  logic         rst;
  logic         wruREAD;
  logic [2:0]   ackPI, statPIH, statPIL;
  logic [7:4]   devINTR [1:4];
  logic [1:4]   devACKO;
  logic [7:4]   devACKBR;
  logic [1:4]   devVACK;
  logic [18:35] devVECT [1:4];
  logic [0:35]  busVECT;
  logic         busVALID, busNOVECT;

  int errors = 0;
  int checks = 0;
  int validCount = 0;
  logic [36:0] expQ [$];

  uba_intack dut (
    .clk      (clk),
    .rst      (rst),
    .wruREAD  (wruREAD),
    .ackPI    (ackPI),
    .statPIH  (statPIH),
    .statPIL  (statPIL),
    .devINTR  (devINTR),
    .devACKO  (devACKO),
    .devACKBR (devACKBR),
    .devVACK  (devVACK),
    .devVECT  (devVECT),
    .busVECT  (busVECT),
    .busVALID (busVALID),
    .busNOVECT(busNOVECT)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every busVALID must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (busVALID === 1'b1) begin
      logic [36:0] e;
      logic [35:0] got;
      validCount++;
      checks++;
      got = busVECT;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got novect=%0b vect=%0o expected no strobe",
                 busNOVECT, got);
      end else begin
        e = expQ.pop_front();
        if ({busNOVECT, got} !== e) begin
          errors++;
          $display("FAIL bus_response: got novect=%0b vect=%0o expected novect=%0b vect=%0o",
                   busNOVECT, got, e[36], e[35:0]);
        end
      end
    end
  end

  task automatic clrIntr();
    for (int d = 1; d <= 4; d++) devINTR[d] = 4'b0000;
  endtask

  // One acknowledge transaction. vackAfter = ACK cycle in which the winner
  // answers (-1 = never). expDev = 0 means nothing eligible.
  task automatic txn(input string name, input logic [2:0] pi, input int expDev,
                     input logic [7:4] expBr, input int vackAfter, input logic [17:0] vec,
                     input logic expNov, input logic [35:0] expVect, input bit disturb);
    int k;
    int v0;
    int other;
    int expHold;
    bit stable;
    logic [1:4] expAcko;
    expAcko = '0;
    if (expDev > 0) expAcko[expDev] = 1'b1;
    expQ.push_back({expNov, expVect});
    v0 = validCount;
    @(posedge clk); #1;
    wruREAD = 1'b1;
    ackPI   = pi;
    @(posedge clk); #1;
    wruREAD = 1'b0;
    ackPI   = ~pi;
    @(negedge clk);
    check({name, "_ack_off_arb"}, {devACKO, devACKBR}, 8'h00);
    @(negedge clk);
    check({name, "_acko_plus2"}, devACKO, expAcko);
    check({name, "_ackbr_plus2"}, devACKBR, expBr);
    if (expDev == 0) begin
      check({name, "_valid_plus2"}, busVALID, 1'b1);
    end else begin
      k = 0;
      stable = 1'b1;
      other = (expDev % 4) + 1;
      while (k < 200) begin
        if (devACKO !== expAcko || devACKBR !== expBr) stable = 1'b0;
        if (k == vackAfter) begin
          devVACK[expDev] = 1'b1;
          devVECT[expDev] = vec;
        end
        if (disturb && k == 1) begin
          wruREAD = 1'b1;
          ackPI   = pi;
          devVACK[other] = 1'b1;
          devVECT[other] = 18'o777777;
          clrIntr();
        end
        @(posedge clk); #1;
        devVACK = '0;
        wruREAD = 1'b0;
        @(negedge clk);
        k++;
        if (devACKO == '0) break;
      end
      expHold = (vackAfter >= 0) ? vackAfter + 1 : 64;
      check({name, "_ack_cycles"}, k, expHold);
      check({name, "_ack_stable"}, stable, 1'b1);
    end
    @(negedge clk);
    @(negedge clk);
    check({name, "_one_valid"}, validCount - v0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    wruREAD = 1'b0;
    ackPI = 3'd0;
    statPIH = 3'd0;
    statPIL = 3'd0;
    devVACK = '0;
    clrIntr();
    for (int d = 1; d <= 4; d++) devVECT[d] = '0;
    @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {devACKO, devACKBR, busVALID, busNOVECT}, 10'h0);
    check("reset_vect", busVECT, 36'h0);
    rst = 1'b1;

    // Basic grant: device 2 on BR6.
    statPIH = 3'd3;
    devINTR[2] = 4'b0100;
    txn("basic", 3'd3, 2, 4'b0100, 4, 18'o000254, 1'b0, 36'o000000000254, 1'b0);
    repeat (3) @(negedge clk);
    check("vect_hold", busVECT, 36'o000000000254);

    // BR7 beats BR6; then lower device number wins within BR7.
    clrIntr();
    statPIH = 3'd2;
    devINTR[4] = 4'b1000;
    devINTR[1] = 4'b0100;
    txn("prio_br7", 3'd2, 4, 4'b1000, 1, 18'o001234, 1'b0, 36'o001234, 1'b0);
    devINTR[3] = 4'b1000;
    txn("prio_dev", 3'd2, 3, 4'b1000, 2, 18'o004321, 1'b0, 36'o004321, 1'b0);

    // Low pair: BR5 beats BR4.
    clrIntr();
    statPIH = 3'd0;
    statPIL = 3'd1;
    devINTR[1] = 4'b0001;
    devINTR[3] = 4'b0010;
    txn("low_br5", 3'd1, 3, 4'b0010, 0, 18'o000070, 1'b0, 36'o000070, 1'b0);

    // Level mismatch: nothing eligible.
    clrIntr();
    statPIL = 3'd5;
    devINTR[1] = 4'b0001;
    devINTR[4] = 4'b0001;
    txn("mismatch", 3'd6, 0, 4'b0000, -1, 18'o0, 1'b1, 36'o0, 1'b0);

    // PI 0 never matches, even against disabled levels.
    clrIntr();
    statPIH = 3'd0;
    statPIL = 3'd0;
    devINTR[1] = 4'b1111;
    txn("pi_zero", 3'd0, 0, 4'b0000, -1, 18'o0, 1'b1, 36'o0, 1'b0);

    // Timeout and last-cycle vector.
    clrIntr();
    statPIH = 3'd3;
    devINTR[2] = 4'b0100;
    txn("timeout", 3'd3, 2, 4'b0100, -1, 18'o0, 1'b1, 36'o0, 1'b0);
    txn("vack_at_63", 3'd3, 2, 4'b0100, 63, 18'o777000, 1'b0, 36'o777000, 1'b0);

    // Disturbance: re-pulsed read, foreign vack, withdrawn requests.
    txn("disturb", 3'd3, 2, 4'b0100, 3, 18'o000456, 1'b0, 36'o000456, 1'b1);

    // Reset during ACK.
    clrIntr();
    devINTR[2] = 4'b0100;
    @(posedge clk); #1;
    wruREAD = 1'b1;
    ackPI = 3'd3;
    @(posedge clk); #1;
    wruREAD = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_acko", devACKO, 4'b0100);
    rst = 1'b0;
    #1;
    check("rst_async_ack", {devACKO, devACKBR}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("rst_no_valid", busVALID, 1'b0);
    check("rst_vect", busVECT, 36'h0);
    rst = 1'b1;
    txn("post_reset", 3'd3, 2, 4'b0100, 2, 18'o000777, 1'b0, 36'o000777, 1'b0);

    check("queue_empty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uba_intack.md
UBA_INTACK -- requirements
Module: uba_intack

Interface
REQ-001 SHALL provide: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL provide: rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-003 SHALL provide: wruREAD  input  1  CPU "who are you" acknowledge request; one-cycle pulse.
REQ-004 SHALL provide: ackPI  input  3  PI level being acknowledged; sampled with wruREAD.
REQ-005 SHALL provide: statPIH  input  3  PI level assigned to BR7/BR6; 0 means disabled.
REQ-006 SHALL provide: statPIL  input  3  PI level assigned to BR5/BR4; 0 means disabled.
REQ-007 SHALL provide: devINTR[1:4]  input  4 each ([7:4])  per-device bus-request lines BR7..BR4.
REQ-008 SHALL provide: devACKO[1:4]  output  1 each  one-hot acknowledge to the winning device.
REQ-009 SHALL provide: devACKBR  output  4 ([7:4])  one-hot BR level being acknowledged.
REQ-010 SHALL provide: devVACK[1:4]  input  1 each  device vector valid.
REQ-011 SHALL provide: devVECT[1:4]  input  18 each ([18:35])  device interrupt vector.
REQ-012 SHALL provide: busVECT  output  36 ([0:35])  vector returned to CPU.
REQ-013 SHALL provide: busVALID  output  1  one-cycle strobe qualifying busVECT.
REQ-014 SHALL provide: busNOVECT  output  1  asserted with busVALID when no device responded.

Function
REQ-015 SHALL implement FSM states IDLE, ARB, ACK, DONE.
REQ-016 IDLE: on wruREAD=1, SHALL latch ackPI and go to ARB; otherwise SHALL stay in IDLE.
REQ-017 wruREAD in any non-IDLE state SHALL be ignored.
REQ-018 ARB: a BR7/BR6 request SHALL be eligible only when statPIH equals the latched ackPI and ackPI is not 0.
REQ-019 ARB: a BR5/BR4 request SHALL be eligible only when statPIL equals the latched ackPI and ackPI is not 0.
REQ-020 ARB priority: BR7 > BR6 > BR5 > BR4; within a BR level, device 1 > 2 > 3 > 4.
REQ-021 ARB: the winner SHALL be latched; the FSM SHALL go to ACK, or to DONE with NOVECT set if nothing is eligible.
REQ-022 ACK: devACKO[winner] and devACKBR[level] SHALL be asserted; all other ACK outputs SHALL be 0.
REQ-023 ACK latency: ACK outputs SHALL first assert 2 cycles after the wruREAD cycle.
REQ-024 ACK: on devVACK[winner]=1, SHALL latch busVECT = {18'b0, devVECT[winner]} and go to DONE.
REQ-025 devVACK from non-winning devices SHALL be ignored.
REQ-026 ACK timeout: a 6-bit counter SHALL clear on entry to ACK and increment each ACK cycle.
REQ-027 ACK timeout: after 64 ACK cycles without devVACK[winner], SHALL go to DONE with NOVECT set and busVECT=0.
REQ-028 Requests changing or withdrawn during ACK SHALL NOT alter the latched winner; waiting SHALL continue until devVACK or timeout.
REQ-029 devVACK[winner] in the same cycle as counter=63 SHALL take priority; the vector is returned with NOVECT=0.
REQ-030 DONE: busVALID SHALL be 1 for exactly one cycle, busNOVECT SHALL equal the NOVECT flag, ACK outputs SHALL be 0, and the next state SHALL be IDLE.
REQ-031 busVECT SHALL hold its value from DONE until the next DONE.
REQ-032 ACK outputs SHALL be registered and glitch-free; they SHALL be 1 only in ACK.

Reset
REQ-033 While rst=0: state SHALL be IDLE; devACKO, devACKBR, busVECT, busVALID, busNOVECT, winner and counter SHALL all be 0.
REQ-034 rst=0 mid-transaction SHALL abort immediately with no busVALID; ACK outputs SHALL deassert asynchronously.
REQ-035 After rst returns to 1, the first wruREAD SHALL be processed normally.

Verification
REQ-036 Basic grant: statPIH=3, devINTR[2][6]=1, wruREAD with ackPI=3; device responds after 4 cycles with vector 0o000254 -> devACKO[2]=1 and devACKBR=4'b0100 from cycle +2; busVALID=1; busVECT=0o000000000254; busNOVECT=0.
REQ-037 Priority: devINTR[4][7] and devINTR[1][6] both set, statPIH=2, ackPI=2 -> device 4 acknowledged at BR7; devINTR[3][7] also set -> device 3 wins over device 4.
REQ-038 Level mismatch: statPIL=5, only BR4 requests, ackPI=6 -> no ACK asserted; busVALID and busNOVECT assert 2 cycles after wruREAD.
REQ-039 Timeout: winner never sends devVACK -> ACK held exactly 64 cycles; then busVALID=1, busNOVECT=1, busVECT=0.
REQ-040 Disturbance: wruREAD re-pulsed and non-winner devVACK during ACK -> both ignored; exactly one busVALID per transaction.
REQ-041 Reset: rst=0 during ACK -> devACKO all 0 immediately; no busVALID; a following transaction completes normally.
